// File: rtl/cdc_frame_sync.sv
// Frame synchroniser on the CDC FIFO egress: hunts for SYNC_WORD at a fixed frame
// period, locks after LOCK_CNT good syncs and forwards aligned frames with sof/eof.
module cdc_frame_sync #(
  parameter int               WIDTH      = 8,
  parameter int               FRAME_LEN  = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 8'h47,
  parameter int               LOCK_CNT   = 3,
  parameter int               UNLOCK_CNT = 2
) (
  input  logic             clk_b,
  input  logic             rst,
  input  logic             data_valid_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             sof_out,
  output logic             eof_out,
  output logic             locked,
  output logic [15:0]      sync_err_cnt
);

  localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW-1:0] POS_LAST    = PW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_TARGET = MW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   pos, pos_next;
  logic [GW-1:0]   good_cnt, good_next, good_inc;
  logic [MW-1:0]   miss_cnt, miss_next, miss_inc;
  logic [15:0]     err_next;
  logic            emit, sof_next, eof_next;
  logic            is_sync, boundary;

  assign is_sync  = (data_b == SYNC_WORD);
  assign boundary = (pos == '0);
  assign good_inc = good_cnt + GW'(1);
  assign miss_inc = miss_cnt + MW'(1);

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state        <= HUNT;
      pos          <= '0;
      good_cnt     <= '0;
      miss_cnt     <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      sof_out      <= 1'b0;
      eof_out      <= 1'b0;
      locked       <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      state        <= state_next;
      pos          <= pos_next;
      good_cnt     <= good_next;
      miss_cnt     <= miss_next;
      valid_out    <= emit;
      sof_out      <= sof_next;
      eof_out      <= eof_next;
      locked       <= (state_next == LOCK);
      sync_err_cnt <= err_next;
      if (emit) begin
        data_out <= data_b;
      end
    end
  end

  // Nothing moves on idle cycles; every decision is taken on an accepted word.
  always_comb begin
    state_next = state;
    pos_next   = pos;
    good_next  = good_cnt;
    miss_next  = miss_cnt;
    err_next   = sync_err_cnt;
    emit       = 1'b0;
    sof_next   = 1'b0;
    eof_next   = 1'b0;

    if (data_valid_b) begin
      pos_next = (pos == POS_LAST) ? '0 : pos + PW'(1);
      case (state)
        HUNT: begin
          if (is_sync) begin
            pos_next  = PW'(1);
            good_next = GW'(1);
            if (LOCK_CNT == 1) begin
              state_next = LOCK;
              miss_next  = '0;
              emit       = 1'b1;
              sof_next   = 1'b1;
            end else begin
              state_next = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_sync) begin
              good_next = good_inc;
              if (good_inc == GOOD_TARGET) begin
                state_next = LOCK;
                miss_next  = '0;
                emit       = 1'b1;
                sof_next   = 1'b1;
              end
            end else begin
              state_next = HUNT;
            end
          end
        end
        LOCK: begin
          emit     = 1'b1;
          sof_next = boundary;
          eof_next = (pos == POS_LAST);
          if (boundary) begin
            if (is_sync) begin
              miss_next = '0;
            end else begin
              miss_next = miss_inc;
              if (sync_err_cnt != 16'hFFFF) begin
                err_next = sync_err_cnt + 16'd1;
              end
              // Losing lock swallows the miss word so no truncated frame escapes.
              if (miss_inc == MISS_TARGET) begin
                state_next = HUNT;
                emit       = 1'b0;
                sof_next   = 1'b0;
              end
            end
          end
        end
        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

endmodule

// File: doc/cdc_frame_sync.md
Name: cdc_frame_sync

Overview:
- Frame synchroniser in the clk_b domain, directly downstream of the CDC FIFO.
- Consumes the FIFO's egress byte stream (data_valid_b/data_b) and hunts for a fixed sync word at a fixed frame period.
- Declares lock after repeated good syncs and forwards aligned frames with start/end markers.
- Flywheels through isolated sync misses and counts sync errors for status.

Parameters:
- WIDTH, 8, data width in bits (equals the CDC FIFO width).
- FRAME_LEN, 16, frame length in words, sync word included; must be ≥ 2.
- SYNC_WORD, 8'h47, sync pattern that occupies word 0 of each frame.
- LOCK_CNT, 3, consecutive good syncs (including the first) needed to enter LOCK; must be ≥ 1.
- UNLOCK_CNT, 2, consecutive missed syncs in LOCK that force a return to HUNT; must be ≥ 1.

Ports:
- clk_b  input  1  egress clock; the only clock in the block.
- rst  input  1  reset, synchronous, active-high.
- data_valid_b  input  1  input word valid, taken from the CDC FIFO.
- data_b  input  WIDTH  input word.
- valid_out  output  1  aligned output word valid.
- data_out  output  WIDTH  aligned output word.
- sof_out  output  1  high with word 0 of a frame.
- eof_out  output  1  high with word FRAME_LEN-1 of a frame.
- locked  output  1  high while in the LOCK state.
- sync_err_cnt  output  16  saturating count of missed syncs while in LOCK.

Behaviour:
- Interface: one clock, clk_b; reset rst is synchronous and active-high. Every state change happens only on a cycle where data_valid_b=1. Idle cycles hold all state and produce valid_out=0.
- Reset: on a clk_b edge with rst=1:
  - state goes to HUNT; pos, good_cnt and miss_cnt clear;
  - valid_out, sof_out, eof_out and locked go to 0; data_out goes to 0; sync_err_cnt goes to 0.
  - Reset asserted mid-frame drops that frame with no eof. The first accepted word after rst deasserts is evaluated in HUNT.
- Position counter: pos runs 0..FRAME_LEN-1 and increments on each accepted word. It wraps to 0 after FRAME_LEN-1. A "boundary word" is an accepted word with pos=0.
- HUNT:
  - When data_b==SYNC_WORD: pos←1, good_cnt←1. If LOCK_CNT=1, go straight to LOCK and treat this word as the first output sof; otherwise go to VERIFY.
  - Any other word: stay in HUNT; pos is don't-care.
- VERIFY:
  - Words count through pos; nothing is output.
  - Boundary word equal to SYNC_WORD: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCK; that boundary word is output as the first word, with sof.
  - Boundary word not equal to SYNC_WORD: go to HUNT. The same word is not re-evaluated as a sync candidate.
- LOCK:
  - Every accepted word is forwarded.
  - sof_out=1 when pos=0; eof_out=1 when pos=FRAME_LEN-1.
  - Boundary word equal to SYNC_WORD: miss_cnt←0.
  - Boundary word not equal to SYNC_WORD: miss_cnt++ and sync_err_cnt++ (saturating at 16'hFFFF).
    - If miss_cnt reaches UNLOCK_CNT, go to HUNT. The miss word is not output and locked falls on the same edge. The previous frame has already ended with eof, so no truncated frame is emitted.
    - Otherwise flywheel: output the word with sof_out=1 and keep going.
- Latency: all outputs are registered, one clk_b cycle after the accepted input word. data_out holds its last value when valid_out=0.
- locked equals (state==LOCK), registered, and is aligned with the output word.
- No backpressure: the block always accepts input, so the FIFO read side is free-running.

Test Plan:
- Lock acquisition (FRAME_LEN=16, LOCK_CNT=3): continuous valid; 8'h47 at input words 0, 16, 32; filler 8'h00..8'h0E elsewhere.
  -> valid_out first rises one cycle after word 32, with data_out=8'h47, sof_out=1 and locked=1.
  -> eof_out=1 one cycle after word 47; no output before that point.
- False sync: 8'h47 at word 5, word 21 = 8'h33, true sync at words 40, 56, 72.
  -> VERIFY aborts at word 21 back to HUNT.
  -> Lock occurs at word 72; sync_err_cnt stays 0.
- Flywheel (UNLOCK_CNT=2): after lock, one frame has sync corrupted to 8'h00.
  -> That frame is still output with sof_out=1 and data_out=8'h00.
  -> sync_err_cnt=1; locked stays 1; the next good sync clears miss_cnt.
- Loss of lock: two consecutive corrupted syncs.
  -> First frame is flywheeled. On the second boundary, valid_out=0 and locked=0.
  -> sync_err_cnt=2. The last output word before loss has eof_out=1.
- Gapped input: data_valid_b toggles 1,0,1,0 across a locked frame.
  -> pos advances only on valid words; output is the 16 words with sof on the first and eof on the 16th.
  -> valid_out is low on the gap cycles.
- Reset mid-frame: rst high for 1 cycle at word 8 of a locked frame.
  -> The next cycle has valid_out=0, locked=0, sync_err_cnt=0.
  -> Relock requires 3 fresh good syncs.
